// File: rtl/ibex_rf_wb_pkg.sv
// ibex_rf_wb_pkg
//   Shared types and constants for the register-file writeback arbiter.
//   wb_src_e    : which requester owns the write port this cycle
//   RF_ADDR_W   : width of all register address ports
//   STALL_CNT_W : width of the EX stall counter
//   rf_eff_addr : drops the address MSB when only 16 registers exist
package ibex_rf_wb_pkg;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_EX,
    WB_SRC_LSU
  } wb_src_e;

  localparam int unsigned RF_ADDR_W   = 5;
  localparam int unsigned STALL_CNT_W = 16;

  function automatic logic [RF_ADDR_W-1:0] rf_eff_addr(input logic [RF_ADDR_W-1:0] addr,
                                                       input bit                    rv32e);
    rf_eff_addr = addr;
    if (rv32e) rf_eff_addr[RF_ADDR_W-1] = 1'b0;
  endfunction

endpackage

// File: rtl/ibex_rf_wb_scoreboard.sv
// ibex_rf_wb_scoreboard
//   Pending-write scoreboard with read-operand hazard lookup.
//   Ports:
//     i_clk, i_rst              : clock, synchronous active-high reset
//     i_set_valid/i_set_addr    : issued instruction will write i_set_addr
//     i_clr_valid/i_clr_addr    : write to i_clr_addr accepted this cycle
//     i_out_we/i_out_waddr      : write currently sitting in the RF output stage
//     i_raddr_a/i_raddr_b       : operand read addresses
//     o_hazard_a/o_hazard_b     : operand not yet readable from the RF
//   All addresses arrive already reduced to the effective width.
module ibex_rf_wb_scoreboard
  import ibex_rf_wb_pkg::*;
#(
  parameter int unsigned RV32E = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_set_valid,
  input  logic [RF_ADDR_W-1:0] i_set_addr,
  input  logic                 i_clr_valid,
  input  logic [RF_ADDR_W-1:0] i_clr_addr,
  input  logic                 i_out_we,
  input  logic [RF_ADDR_W-1:0] i_out_waddr,
  input  logic [RF_ADDR_W-1:0] i_raddr_a,
  input  logic [RF_ADDR_W-1:0] i_raddr_b,
  output logic                 o_hazard_a,
  output logic                 o_hazard_b
);

  localparam int unsigned ADDR_W = (RV32E != 0) ? 4 : 5;
  localparam int unsigned NREG   = 1 << ADDR_W;

  logic [NREG-1:0]   r_pending;
  logic [NREG-1:0]   w_pending_nxt;
  logic [ADDR_W-1:0] w_set_idx;
  logic [ADDR_W-1:0] w_clr_idx;
  logic [ADDR_W-1:0] w_rd_a_idx;
  logic [ADDR_W-1:0] w_rd_b_idx;
  logic              w_hit_a;
  logic              w_hit_b;

  assign w_set_idx  = i_set_addr[ADDR_W-1:0];
  assign w_clr_idx  = i_clr_addr[ADDR_W-1:0];
  assign w_rd_a_idx = i_raddr_a[ADDR_W-1:0];
  assign w_rd_b_idx = i_raddr_b[ADDR_W-1:0];

  // Clear is applied before set so that a same-cycle issue to the same
  // register leaves the entry pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_clr_valid) w_pending_nxt[w_clr_idx] = 1'b0;
    if (i_set_valid) w_pending_nxt[w_set_idx] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_pending <= '0;
    else       r_pending <= w_pending_nxt;
  end

  // The RF latches the output-stage write one edge later, so that stage
  // still counts as not readable.
  assign w_hit_a    = i_out_we && (i_out_waddr == i_raddr_a);
  assign w_hit_b    = i_out_we && (i_out_waddr == i_raddr_b);
  assign o_hazard_a = (i_raddr_a != '0) && (r_pending[w_rd_a_idx] || w_hit_a);
  assign o_hazard_b = (i_raddr_b != '0) && (r_pending[w_rd_b_idx] || w_hit_b);

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// ibex_rf_wb_arbiter
//   Arbitrates EX and LSU writebacks onto one registered RF write port
//   (LSU has fixed priority), tracks pending writes for operand hazards
//   and optionally counts EX stall cycles.
//   Ports:
//     clk_i, rst_i                          : clock, synchronous active-high reset
//     ex_valid_i/ex_waddr_i/ex_wdata_i      : EX writeback request, ex_ready_o accept
//     lsu_valid_i/lsu_waddr_i/lsu_wdata_i   : load writeback request, lsu_ready_o accept
//     issue_valid_i/issue_waddr_i           : issued instruction destination
//     rf_we_o/rf_waddr_o/rf_wdata_o         : registered RF write port
//     raddr_a_i/raddr_b_i, hazard_a_o/b_o   : operand hazard lookup
//     stall_cnt_o                           : saturating EX stall cycle count
//   Configuration macro IBEX_RF_WB_STALL_CNT_EN: enables the stall counter;
//   when undefined stall_cnt_o is tied to zero.
module ibex_rf_wb_arbiter
  import ibex_rf_wb_pkg::*;
#(
  parameter int unsigned RV32E     = 0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ex_valid_i,
  input  logic [RF_ADDR_W-1:0]   ex_waddr_i,
  input  logic [DataWidth-1:0]   ex_wdata_i,
  output logic                   ex_ready_o,
  input  logic                   lsu_valid_i,
  input  logic [RF_ADDR_W-1:0]   lsu_waddr_i,
  input  logic [DataWidth-1:0]   lsu_wdata_i,
  output logic                   lsu_ready_o,
  input  logic                   issue_valid_i,
  input  logic [RF_ADDR_W-1:0]   issue_waddr_i,
  output logic                   rf_we_o,
  output logic [RF_ADDR_W-1:0]   rf_waddr_o,
  output logic [DataWidth-1:0]   rf_wdata_o,
  input  logic [RF_ADDR_W-1:0]   raddr_a_i,
  input  logic [RF_ADDR_W-1:0]   raddr_b_i,
  output logic                   hazard_a_o,
  output logic                   hazard_b_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam bit IS_E = (RV32E != 0);

  wb_src_e              w_src;
  logic [RF_ADDR_W-1:0] w_waddr;
  logic [DataWidth-1:0] w_wdata;
  logic                 w_accept;
  logic                 w_ex_ready;
  logic                 r_we;
  logic [RF_ADDR_W-1:0] r_waddr;
  logic [DataWidth-1:0] r_wdata;

  assign lsu_ready_o = !rst_i;
  assign w_ex_ready  = !rst_i && !lsu_valid_i;
  assign ex_ready_o  = w_ex_ready;

  always_comb begin
    w_src   = WB_SRC_NONE;
    w_waddr = '0;
    w_wdata = '0;
    if (!rst_i) begin
      if (lsu_valid_i) begin
        w_src   = WB_SRC_LSU;
        w_waddr = rf_eff_addr(lsu_waddr_i, IS_E);
        w_wdata = lsu_wdata_i;
      end else if (ex_valid_i) begin
        w_src   = WB_SRC_EX;
        w_waddr = rf_eff_addr(ex_waddr_i, IS_E);
        w_wdata = ex_wdata_i;
      end
    end
  end

  assign w_accept = (w_src != WB_SRC_NONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= (w_waddr != '0);
      r_waddr <= w_waddr;
      r_wdata <= w_wdata;
    end else begin
      r_we    <= 1'b0;
    end
  end

  // Reset also kills a write already in the output stage.
  assign rf_we_o    = r_we && !rst_i;
  assign rf_waddr_o = r_waddr;
  assign rf_wdata_o = r_wdata;

  ibex_rf_wb_scoreboard #(
    .RV32E (RV32E)
  ) u_scoreboard (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_set_valid (issue_valid_i),
    .i_set_addr  (rf_eff_addr(issue_waddr_i, IS_E)),
    .i_clr_valid (w_accept),
    .i_clr_addr  (w_waddr),
    .i_out_we    (rf_we_o),
    .i_out_waddr (r_waddr),
    .i_raddr_a   (rf_eff_addr(raddr_a_i, IS_E)),
    .i_raddr_b   (rf_eff_addr(raddr_b_i, IS_E)),
    .o_hazard_a  (hazard_a_o),
    .o_hazard_b  (hazard_b_o)
  );

`ifdef IBEX_RF_WB_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (ex_valid_i && !w_ex_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// tb_ibex_rf_wb_arbiter
//   Drives two instances (RV32E = 0 and RV32E = 1) with shared inputs and
//   compares both against a reference model built from arrays and integers.
module tb_ibex_rf_wb_arbiter;

`ifdef IBEX_RF_WB_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, lsu_valid, issue_valid;
  logic [4:0]  ex_waddr, lsu_waddr, issue_waddr, raddr_a, raddr_b;
  logic [31:0] ex_wdata, lsu_wdata;

  logic [1:0]  ex_ready, lsu_ready, rf_we, haz_a, haz_b;
  logic [4:0]  rf_waddr [2];
  logic [31:0] rf_wdata [2];
  logic [15:0] stall    [2];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // reference model state, index = instance (1 means 16 registers)
  bit          m_we    [2];
  int unsigned m_waddr [2];
  logic [31:0] m_wdata [2];
  bit          m_pend  [2][32];
  int unsigned m_stall;

  always #5 clk = ~clk;

  ibex_rf_wb_arbiter #(.RV32E(0), .DataWidth(32)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready[0]),
    .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(lsu_ready[0]),
    .issue_valid_i(issue_valid), .issue_waddr_i(issue_waddr),
    .rf_we_o(rf_we[0]), .rf_waddr_o(rf_waddr[0]), .rf_wdata_o(rf_wdata[0]),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .hazard_a_o(haz_a[0]), .hazard_b_o(haz_b[0]), .stall_cnt_o(stall[0])
  );

  ibex_rf_wb_arbiter #(.RV32E(1), .DataWidth(32)) u_dut_e (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready[1]),
    .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata), .lsu_ready_o(lsu_ready[1]),
    .issue_valid_i(issue_valid), .issue_waddr_i(issue_waddr),
    .rf_we_o(rf_we[1]), .rf_waddr_o(rf_waddr[1]), .rf_wdata_o(rf_wdata[1]),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .hazard_a_o(haz_a[1]), .hazard_b_o(haz_b[1]), .stall_cnt_o(stall[1])
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int unsigned eff(input logic [4:0] a, input int k);
    return (k == 1) ? (int'(a) % 16) : int'(a);
  endfunction

  function automatic bit exp_haz(input int k, input logic [4:0] ra);
    int unsigned a = eff(ra, k);
    bit out_we = m_we[k] && !rst;
    if (a == 0) return 1'b0;
    return m_pend[k][a] || (out_we && (m_waddr[k] == a));
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_we[k] = 1'b0; m_waddr[k] = 0; m_wdata[k] = '0;
        for (int i = 0; i < 32; i++) m_pend[k][i] = 1'b0;
      end else begin
        if (lsu_valid || ex_valid) begin
          int unsigned a = lsu_valid ? eff(lsu_waddr, k) : eff(ex_waddr, k);
          m_waddr[k] = a;
          m_wdata[k] = lsu_valid ? lsu_wdata : ex_wdata;
          m_we[k]    = (a != 0);
          m_pend[k][a] = 1'b0;
        end else begin
          m_we[k] = 1'b0;
        end
        if (issue_valid && eff(issue_waddr, k) != 0) m_pend[k][eff(issue_waddr, k)] = 1'b1;
      end
    end
    if (rst) m_stall = 0;
    else if (ex_valid && lsu_valid && m_stall < 65535) m_stall++;
  endtask

  // One clock: check combinational outputs for the current inputs, clock,
  // then check registered outputs.
  task automatic cycle();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("lsu_ready[%0d]", k), lsu_ready[k], !rst);
      chk($sformatf("ex_ready[%0d]", k), ex_ready[k], !rst && !lsu_valid);
      chk($sformatf("rf_we_comb[%0d]", k), rf_we[k], m_we[k] && !rst);
      if (!rst) begin
        chk($sformatf("haz_a[%0d]", k), haz_a[k], exp_haz(k, raddr_a));
        chk($sformatf("haz_b[%0d]", k), haz_b[k], exp_haz(k, raddr_b));
      end
    end
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rf_we[%0d]", k), rf_we[k], m_we[k] && !rst);
      chk($sformatf("rf_waddr[%0d]", k), rf_waddr[k], m_waddr[k]);
      chk($sformatf("rf_wdata[%0d]", k), rf_wdata[k], m_wdata[k]);
      chk($sformatf("stall[%0d]", k), stall[k], STALL_EN ? m_stall : 0);
    end
  endtask

  task automatic idle();
    rst = 1'b0; ex_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
  endtask

  initial begin
    m_stall = 0;
    for (int k = 0; k < 2; k++) begin
      m_we[k] = 1'b0; m_waddr[k] = 0; m_wdata[k] = '0;
      for (int i = 0; i < 32; i++) m_pend[k][i] = 1'b0;
    end
    idle();
    ex_waddr = '0; lsu_waddr = '0; issue_waddr = '0; raddr_a = '0; raddr_b = '0;
    ex_wdata = '0; lsu_wdata = '0;

    rst = 1'b1; cycle(); cycle();
    chk("reset_we", rf_we[0], 1'b0);
    chk("reset_waddr", rf_waddr[0], 5'd0);
    chk("reset_wdata", rf_wdata[0], 32'd0);
    chk("reset_stall", stall[0], 16'd0);

    // basic EX write then idle
    idle(); ex_valid = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'hDEADBEEF; cycle();
    chk("ex_we", rf_we[0], 1'b1);
    chk("ex_waddr", rf_waddr[0], 5'd5);
    chk("ex_wdata", rf_wdata[0], 32'hDEADBEEF);
    idle(); cycle();
    chk("ex_we_drop", rf_we[0], 1'b0);
    chk("ex_hold_wdata", rf_wdata[0], 32'hDEADBEEF);

    // LSU priority and EX retry
    rst = 1'b1; cycle(); idle();
    ex_valid = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'h33;
    lsu_valid = 1'b1; lsu_waddr = 5'd7; lsu_wdata = 32'h77;
    #1 chk("prio_ex_ready", ex_ready[0], 1'b0);
    cycle();
    chk("prio_lsu_first", rf_waddr[0], 5'd7);
    lsu_valid = 1'b0; cycle();
    chk("prio_ex_second", rf_waddr[0], 5'd3);
    chk("prio_ex_wdata", rf_wdata[0], 32'h33);
    chk("prio_stall", stall[0], STALL_EN ? 16'd1 : 16'd0);

    // hazard through the output stage
    idle(); issue_valid = 1'b1; issue_waddr = 5'd9; cycle();
    idle(); raddr_a = 5'd9; #1 chk("haz_pending", haz_a[0], 1'b1);
    ex_valid = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'h99; cycle();
    chk("haz_out_stage", haz_a[0], 1'b1);
    idle(); cycle();
    chk("haz_cleared", haz_a[0], 1'b0);

    // same-cycle set and clear
    idle(); issue_valid = 1'b1; issue_waddr = 5'd4;
    ex_valid = 1'b1; ex_waddr = 5'd4; ex_wdata = 32'h44; raddr_b = 5'd4; cycle();
    idle(); cycle();
    chk("set_wins", haz_b[0], 1'b1);

    // address 0 and RV32E truncation
    idle(); ex_valid = 1'b1; ex_waddr = 5'd0; cycle();
    chk("waddr0_we", rf_we[0], 1'b0);
    ex_waddr = 5'b10010; cycle();
    chk("e_waddr", rf_waddr[1], 5'd2);
    chk("e_we", rf_we[1], 1'b1);
    chk("full_waddr", rf_waddr[0], 5'd18);

    // reset right after acceptance
    idle(); issue_valid = 1'b1; issue_waddr = 5'd6; cycle();
    idle(); ex_valid = 1'b1; ex_waddr = 5'd6; ex_wdata = 32'h66; cycle();
    idle(); rst = 1'b1; raddr_a = 5'd6; raddr_b = 5'd4;
    #1 chk("rst_kill_we", rf_we[0], 1'b0);
    cycle();
    idle(); #1;
    chk("rst_haz_a", haz_a[0], 1'b0);
    chk("rst_haz_b", haz_b[0], 1'b0);
    chk("rst_we", rf_we[0], 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 39) == 0);
      ex_valid    = $urandom_range(0, 1);
      lsu_valid   = ($urandom_range(0, 2) == 0);
      issue_valid = $urandom_range(0, 1);
      ex_waddr    = 5'($urandom);
      lsu_waddr   = 5'($urandom);
      issue_waddr = 5'($urandom);
      raddr_a     = 5'($urandom);
      raddr_b     = 5'($urandom);
      ex_wdata    = $urandom;
      lsu_wdata   = $urandom;
      cycle();
    end

`ifdef IBEX_RF_WB_STALL_CNT_EN
    idle(); rst = 1'b1; cycle();
    idle(); ex_valid = 1'b1; lsu_valid = 1'b1; lsu_waddr = 5'd1; ex_waddr = 5'd2;
    for (int n = 0; n < 70000; n++) cycle();
    chk("stall_sat", stall[0], 16'hFFFF);
`else
    idle(); ex_valid = 1'b1; lsu_valid = 1'b1;
    for (int n = 0; n < 20; n++) cycle();
    chk("stall_tied", stall[0], 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ibex_rf_wb_arbiter.md
IBEX_RF_WB_ARBITER -- requirements
Module: ibex_rf_wb_arbiter

Interface
REQ-001 Parameter RV32E, default 0: 1 gives 16 registers, 4-bit effective address; 0 gives 32 registers, 5-bit effective address.
REQ-002 Parameter DataWidth, default 32: register data width.
REQ-003 Port clk_i  in  1: single clock; all state on rising edge.
REQ-004 Port rst_i  in  1: reset, synchronous and active-high.
REQ-005 Port ex_valid_i / ex_waddr_i / ex_wdata_i  in  1/5/DataWidth: EX writeback request.
REQ-006 Port ex_ready_o  out  1: EX request accepted this cycle when high with ex_valid_i.
REQ-007 Port lsu_valid_i / lsu_waddr_i / lsu_wdata_i  in  1/5/DataWidth: load writeback request.
REQ-008 Port lsu_ready_o  out  1: LSU request accepted this cycle when high with lsu_valid_i.
REQ-009 Port issue_valid_i / issue_waddr_i  in  1/5: instruction issued that will write issue_waddr_i.
REQ-010 Port rf_we_o / rf_waddr_o / rf_wdata_o  out  1/5/DataWidth: registered register-file write port.
REQ-011 Port raddr_a_i / raddr_b_i  in  5/5: decode read addresses.
REQ-012 Port hazard_a_o / hazard_b_o  out  1/1: read operand not yet written.
REQ-013 Port stall_cnt_o  out  16: EX stall cycle count.

Function
REQ-014 Only the low ADDR_WIDTH address bits are used on all address inputs.
REQ-015 Arbitration: LSU has fixed priority; lsu_ready_o is always 1 unless rst_i is high; ex_ready_o = !lsu_valid_i and !rst_i.
REQ-016 An accepted request is registered: rf_we_o, rf_waddr_o and rf_wdata_o reflect it exactly one cycle after acceptance.
REQ-017 When no request is accepted, rf_we_o is 0 next cycle, and rf_waddr_o and rf_wdata_o hold their previous values.
REQ-018 Writes to address 0 are accepted but produce rf_we_o = 0.
REQ-019 Scoreboard: pending[i] is set on issue_valid_i with address i (i != 0).
REQ-020 Scoreboard: pending[i] is cleared when a write to address i is accepted.
REQ-021 Simultaneous set and clear of the same entry: set wins.
REQ-022 pending[0] is constant 0.
REQ-023 hazard_x_o = pending[raddr_x] OR (rf_we_o AND rf_waddr_o == raddr_x); combinational; 0 for address 0.
REQ-024 Rationale for REQ-023: the RF captures write data one edge later, so the output stage is not yet readable.
REQ-025 An EX stall cycle is a cycle with ex_valid_i = 1 and ex_ready_o = 0.
REQ-026 stall_cnt_o increments once per EX stall cycle and saturates at 16'hFFFF.

Reset
REQ-027 In any cycle with rst_i high, next state is: rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, all pending bits 0, stall_cnt_o = 0.
REQ-028 While rst_i is high, both ready outputs are 0 and requests are dropped, including any write in flight in the output stage.

Configuration
REQ-029 Macro IBEX_RF_WB_STALL_CNT_EN defined: the stall counter of REQ-025/026 is implemented.
REQ-030 Macro IBEX_RF_WB_STALL_CNT_EN undefined: no counter flops exist and stall_cnt_o is tied to 0.

Structure
REQ-031 Package ibex_rf_wb_pkg holds: wb_src_e {WB_SRC_NONE, WB_SRC_EX, WB_SRC_LSU}, constant RF_ADDR_W = 5, constant STALL_CNT_W = 16.
REQ-032 Sub-module ibex_rf_wb_scoreboard contains the pending vector, its set/clear logic and the hazard lookup.
REQ-033 ibex_rf_wb_scoreboard is parameterised by RV32E.

Verification
REQ-034 Reset, then EX request waddr 5, wdata 32'hDEADBEEF -> next cycle rf_we_o = 1, rf_waddr_o = 5, rf_wdata_o = 32'hDEADBEEF; following cycle rf_we_o = 0.
REQ-035 EX (waddr 3) and LSU (waddr 7) both valid for 1 cycle -> LSU written first, ex_ready_o = 0; EX waddr 3 written one cycle later; stall_cnt_o = 1 with macro, 0 without.
REQ-036 Issue waddr 9, then raddr_a_i = 9 -> hazard_a_o = 1; hazard_a_o stays 1 while the write to 9 sits in the output stage; it drops to 0 the cycle after.
REQ-037 Issue waddr 4 and EX write waddr 4 in the same cycle -> pending[4] remains set and hazard on 4 is 1.
REQ-038 EX write to waddr 0, and RV32E = 1 with waddr 5'b10010 -> first gives rf_we_o = 0; second gives rf_waddr_o effective address 2.
REQ-039 Assert rst_i the cycle after acceptance -> rf_we_o = 0, no write emitted, all hazards 0.
REQ-040 LSU valid held 70000 cycles with EX valid (macro defined) -> stall_cnt_o saturates at 16'hFFFF.
